// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the IFM window feeder state encoding.
package cnn_pkg;

    localparam int PIX_W    = 8;
    localparam int WORD_PIX = 4;
    localparam int WORD_W   = PIX_W * WORD_PIX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FET0,
        ST_FET1,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } feeder_state_t;

endpackage

// File: rtl/ifm_window_feeder_if.sv
// Bus bundles for the window feeder: IFM memory read port and PE pixel stream.
interface ifm_mem_if #(parameter int ADDR_W = 8);
    import cnn_pkg::*;

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input  mem_data);
    modport slave  (input  mem_rd, input  mem_addr, output mem_data);
endinterface

interface ifm_pix_if;
    import cnn_pkg::*;

    logic [PIX_W-1:0] pix;
    logic             pix_valid;
    logic             pix_ready;
    logic [3:0]       filt_idx;
    logic             win_first;
    logic             win_last;

    modport master (output pix, output pix_valid, input  pix_ready,
                    output filt_idx, output win_first, output win_last);
    modport slave  (input  pix, input  pix_valid, output pix_ready,
                    input  filt_idx, input  win_first, input  win_last);
endinterface

// File: rtl/window_row_stager.sv
// Two-word (8-pixel) staging register for one window row, read by lane index.
module window_row_stager
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_lo_i,
    input  logic              load_hi_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [2:0]        sel_i,
    output logic [PIX_W-1:0]  pix_o
);

    // Lane k of a word lands in stage_q[k] (low word) or stage_q[k+4] (high word).
    logic [2*WORD_PIX-1:0][PIX_W-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            if (load_lo_i) stage_q[WORD_PIX-1:0]          <= word_i;
            if (load_hi_i) stage_q[2*WORD_PIX-1:WORD_PIX] <= word_i;
        end
    end

    assign pix_o = stage_q[sel_i];

endmodule

// File: rtl/ifm_window_feeder.sv
// Walks the IFM in convolution-window order and streams one activation per
// accepted cycle to the PE, fetching each window row as two memory words.
module ifm_window_feeder
    import cnn_pkg::*;
#(
    parameter int IFM_W  = 8,
    parameter int IFM_H  = 8,
    parameter int FILT   = 4,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    ifm_mem_if.master         mem,
    ifm_pix_if.master         px,
    output logic              busy_o,
    output logic              done_o
);

    // state | meaning
    // IDLE  | waiting for start
    // FET0  | read word A (first word of the window row)
    // FET1  | read word A+1, capture word A
    // WAIT  | capture word A+1
    // EMIT  | present one row pixel per accept
    // DONE  | one-cycle done pulse

    localparam int         ROW_WORDS = IFM_W / WORD_PIX;
    localparam logic [7:0] OX_LAST   = 8'((IFM_W - FILT) / STRIDE);
    localparam logic [7:0] OY_LAST   = 8'((IFM_H - FILT) / STRIDE);
    localparam logic [3:0] F_LAST    = 4'(FILT - 1);

    feeder_state_t state_q, state_d;
    logic [7:0]    oy_q, oy_d, ox_q, ox_d;
    logic [3:0]    wr_q, wr_d, wc_q, wc_d;

    logic [ADDR_W-1:0] row_a, c0_a, addr_a;
    logic [2:0]        lane_sel;
    logic [PIX_W-1:0]  stage_pix;
    logic              load_lo, load_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            oy_q    <= '0;
            ox_q    <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
        end
    end

    // Row start word; the window's first column may sit at any lane of it.
    always_comb begin
        row_a    = ADDR_W'(oy_q) * ADDR_W'(STRIDE) + ADDR_W'(wr_q);
        c0_a     = ADDR_W'(ox_q) * ADDR_W'(STRIDE);
        addr_a   = base_addr_i + row_a * ADDR_W'(ROW_WORDS) + (c0_a >> 2);
        lane_sel = 3'(c0_a[1:0]) + 3'(wc_q);
    end

    window_row_stager u_stager (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_lo_i (load_lo),
        .load_hi_i (load_hi),
        .word_i    (mem.mem_data),
        .sel_i     (lane_sel),
        .pix_o     (stage_pix)
    );

    always_comb begin
        state_d      = state_q;
        oy_d         = oy_q;
        ox_d         = ox_q;
        wr_d         = wr_q;
        wc_d         = wc_q;
        load_lo      = 1'b0;
        load_hi      = 1'b0;
        mem.mem_rd   = 1'b0;
        mem.mem_addr = '0;
        px.pix       = '0;
        px.pix_valid = 1'b0;
        px.filt_idx  = '0;
        px.win_first = 1'b0;
        px.win_last  = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    oy_d    = '0;
                    ox_d    = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    state_d = ST_FET0;
                end
            end
            ST_FET0: begin
                busy_o       = 1'b1;
                mem.mem_rd   = 1'b1;
                mem.mem_addr = addr_a;
                state_d      = ST_FET1;
            end
            ST_FET1: begin
                busy_o       = 1'b1;
                mem.mem_rd   = 1'b1;
                mem.mem_addr = addr_a + ADDR_W'(1);
                load_lo      = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                busy_o  = 1'b1;
                load_hi = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                busy_o       = 1'b1;
                px.pix_valid = 1'b1;
                px.pix       = stage_pix;
                px.filt_idx  = wr_q * 4'(FILT) + wc_q;
                px.win_first = (wr_q == '0) && (wc_q == '0);
                px.win_last  = (wr_q == F_LAST) && (wc_q == F_LAST);
                if (px.pix_ready) begin
                    if (wc_q != F_LAST) begin
                        wc_d = wc_q + 4'd1;
                    end else begin
                        wc_d    = '0;
                        state_d = ST_FET0;
                        if (wr_q != F_LAST) begin
                            wr_d = wr_q + 4'd1;
                        end else begin
                            wr_d = '0;
                            if (ox_q != OX_LAST) begin
                                ox_d = ox_q + 8'd1;
                            end else begin
                                ox_d = '0;
                                if (oy_q != OY_LAST) begin
                                    oy_d = oy_q + 8'd1;
                                end else begin
                                    oy_d    = '0;
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifm_window_feeder.sv
// Scoreboard bench for ifm_window_feeder: stride-1 instance fully scored, stride-2 instance spot-checked.
module tb_ifm_window_feeder;
    import cnn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] base = 8'h00;
    logic [7:0] base2 = 8'h00;
    logic       busy1, done1, busy2, done2;

    always #5 clk = ~clk;

    ifm_mem_if #(.ADDR_W(8)) mem1 ();
    ifm_pix_if               px1 ();
    ifm_mem_if #(.ADDR_W(8)) mem2 ();
    ifm_pix_if               px2 ();

    ifm_window_feeder #(.IFM_W(8), .IFM_H(8), .FILT(4), .STRIDE(1), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base),
        .mem(mem1), .px(px1), .busy_o(busy1), .done_o(done1));

    ifm_window_feeder #(.IFM_W(8), .IFM_H(8), .FILT(4), .STRIDE(2), .ADDR_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .base_addr_i(base2),
        .mem(mem2), .px(px2), .busy_o(busy2), .done_o(done2));

    // pixel(r,c) = r*8+c with two words per row, so byte k of word offset w is w*4+k.
    function automatic logic [31:0] mem_word(input logic [7:0] off);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(off * 4 + k);
        return w;
    endfunction

    always @(posedge clk) if (mem1.mem_rd) mem1.mem_data <= mem_word(mem1.mem_addr - base);
    always @(posedge clk) if (mem2.mem_rd) mem2.mem_data <= mem_word(mem2.mem_addr - base2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard for the stride-1 instance: {pix, filt_idx, win_first, win_last}.
    logic [14:0] exp_q[$];

    task automatic push_pass();
        for (int oy = 0; oy < 5; oy++)
            for (int ox = 0; ox < 5; ox++)
                for (int wr = 0; wr < 4; wr++)
                    for (int wc = 0; wc < 4; wc++)
                        exp_q.push_back({8'((oy + wr) * 8 + ox + wc), 4'(wr * 4 + wc),
                                         (wr == 0 && wc == 0), (wr == 3 && wc == 3)});
    endtask

    int          acc_cnt, done_cnt, first_valid_cyc, win_cnt, win2_cyc;
    bit          hold_pend = 1'b0;
    logic [14:0] held;

    task automatic clr_mon();
        acc_cnt = 0; done_cnt = 0; first_valid_cyc = -1; win_cnt = 0; win2_cyc = -1;
    endtask

    always @(negedge clk) begin : mon1
        logic [14:0] cur;
        logic [14:0] exp;
        cur = {px1.pix, px1.filt_idx, px1.win_first, px1.win_last};
        if (done1) done_cnt++;
        if (hold_pend) begin
            n_vec++;
            if (!px1.pix_valid || cur !== held) begin
                n_bad++;
                $display("FAIL stall_hold: got valid=%0b word=%h expected valid=1 word=%h",
                         px1.pix_valid, cur, held);
            end
        end
        hold_pend = px1.pix_valid && !px1.pix_ready;
        held      = cur;
        if (px1.pix_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (px1.pix_ready) begin
                if (px1.win_first) begin
                    win_cnt++;
                    if (win_cnt == 2) win2_cyc = cyc;
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pixel[%0d]: got pix=%0d with no pixel expected", acc_cnt, px1.pix);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        n_bad++;
                        $display("FAIL pixel[%0d]: got pix=%0d filt=%0d f=%0b l=%0b expected pix=%0d filt=%0d f=%0b l=%0b",
                                 acc_cnt, cur[14:7], cur[6:3], cur[1], cur[0],
                                 exp[14:7], exp[6:3], exp[1], exp[0]);
                    end
                end
                acc_cnt++;
            end
        end
    end

    int acc2 = 0, win2_n = 0, sec_first2 = -1, last_pix2 = -1;
    always @(negedge clk) begin : mon2
        if (px2.pix_valid && px2.pix_ready) begin
            acc2++;
            if (px2.win_first) begin
                win2_n++;
                if (win2_n == 2) sec_first2 = px2.pix;
            end
            last_pix2 = px2.pix;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit start_in_done);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done1) begin seen = 1'b1; break; end
        end
        chk("done_seen", int'(seen), 1);
        if (seen && start_in_done) pulse_start();
    endtask

    task automatic wait_acc(input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc_cnt >= n) begin ok = 1'b1; break; end
        end
        chk("acc_reached", int'(ok), 1);
    endtask

    int t0;

    initial begin
        px1.pix_ready = 1'b1;
        px2.pix_ready = 1'b1;
        mem1.mem_data = '0;
        mem2.mem_data = '0;
        clr_mon();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_rd", int'(mem1.mem_rd), 0);
        chk("rst_mem_addr", int'(mem1.mem_addr), 0);
        chk("rst_pix_valid", int'(px1.pix_valid), 0);
        chk("rst_pix", int'(px1.pix), 0);
        chk("rst_filt_idx", int'(px1.filt_idx), 0);
        chk("rst_win_first", int'(px1.win_first), 0);
        chk("rst_win_last", int'(px1.win_last), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass 1: aligned base, no stalls; timing of first pixel and second window.
        base = 8'h10;
        push_pass();
        clr_mon();
        t0 = cyc;
        pulse_start();
        chk("busy_after_start", int'(busy1), 1);
        wait_done(1000, 1'b0);
        chk("first_valid_latency", first_valid_cyc - t0, 4);
        chk("win2_offset", win2_cyc - first_valid_cyc, 28);
        chk("p1_pixels", acc_cnt, 400);
        chk("p1_windows", win_cnt, 25);
        chk("p1_queue_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("p1_done_pulses", done_cnt, 1);
        chk("p1_busy_after", int'(busy1), 0);

        // Pass 2: wrapping base, 3-cycle stall mid-row, start while busy and in DONE.
        base = 8'hF8;
        push_pass();
        clr_mon();
        pulse_start();
        wait_acc(6, 200);
        px1.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        px1.pix_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pulse_start();
        wait_done(1000, 1'b1);
        chk("p2_pixels", acc_cnt, 400);
        chk("p2_queue_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("p2_done_pulses", done_cnt, 1);
        chk("p2_busy_after", int'(busy1), 0);

        // Reset during EMIT: outputs drop at once and no done follows.
        base = 8'h10;
        push_pass();
        clr_mon();
        pulse_start();
        wait_acc(37, 300);
        chk("mid_emit_valid", int'(px1.pix_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_pix_valid", int'(px1.pix_valid), 0);
        chk("rstmid_pix", int'(px1.pix), 0);
        chk("rstmid_filt", int'(px1.filt_idx), 0);
        chk("rstmid_busy", int'(busy1), 0);
        chk("rstmid_mem_rd", int'(mem1.mem_rd), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_idle", int'(busy1), 0);

        // Fresh pass after reset replays from pixel 0.
        push_pass();
        clr_mon();
        t0 = cyc;
        pulse_start();
        wait_done(1000, 1'b0);
        chk("p3_first_latency", first_valid_cyc - t0, 4);
        chk("p3_pixels", acc_cnt, 400);
        chk("p3_queue_left", exp_q.size(), 0);

        // Stride-2 instance.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        begin
            bit seen2 = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk); #1;
                if (done2) begin seen2 = 1'b1; break; end
            end
            chk("s2_done_seen", int'(seen2), 1);
        end
        @(posedge clk); #1;
        chk("s2_windows", win2_n, 9);
        chk("s2_pixels", acc2, 144);
        chk("s2_win2_first_pix", sec_first2, 2);
        chk("s2_last_pix", last_pix2, 63);
        chk("s2_busy_after", int'(busy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
